// File: rtl/display_sched_pkg.sv
// Shared types and constants for the time-display scheduler.
// Seconds-of-day values are 17 bits wide, covering 0..86399.
package display_pkg;

  typedef enum logic [1:0] {
    SHOW_CLOCK = 2'd0,
    SHOW_ALARM = 2'd1,
    EDIT       = 2'd2,
    RING       = 2'd3
  } view_state_t;

  typedef enum logic [1:0] {
    FIELD_SEC  = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_HOUR = 2'd2,
    FIELD_NONE = 2'd3
  } edit_field_t;

  localparam logic [16:0] SECS_PER_DAY = 17'd86400;
  localparam logic [16:0] NIGHT_START  = 17'd79200;
  localparam logic [16:0] NIGHT_END    = 17'd25200;

  localparam logic [5:0] MASK_SEC  = 6'b000011;
  localparam logic [5:0] MASK_MIN  = 6'b001100;
  localparam logic [5:0] MASK_HOUR = 6'b110000;
  localparam logic [5:0] MASK_NONE = 6'b000000;
  localparam logic [5:0] MASK_ALL  = 6'b111111;

  function automatic logic [5:0] field_mask(input logic [1:0] field);
    logic [5:0] mask;
    case (edit_field_t'(field))
      FIELD_SEC:  mask = MASK_SEC;
      FIELD_MIN:  mask = MASK_MIN;
      FIELD_HOUR: mask = MASK_HOUR;
      default:    mask = MASK_NONE;
    endcase
    return mask;
  endfunction

  // Night spans midnight, so it is the union of the two ends of the day.
  function automatic logic is_night(input logic [16:0] t);
    return (t >= NIGHT_START) || (t < NIGHT_END);
  endfunction

endpackage

// File: rtl/display_sched_tick_gen.sv
// Free-running divider: a registered one-cycle pulse every DIV clock cycles.
// The first pulse appears DIV cycles after reset release.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;

  // Wrapping counter with the pulse registered on the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
      tick  <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_r <= cnt_r + 1'b1;
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/display_sched.sv
// Chooses the value and blank mask shown on the 6-digit time display.
// Optional night dimming is enabled by defining NIGHT_DIM_EN.
module display_sched
  import display_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLINK_HZ       = 2,
  parameter int VIEW_TIMEOUT_S = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] cur_time,
  input  logic [16:0] alarm_time,
  input  logic [16:0] edit_time,
  input  logic        edit_active,
  input  logic [1:0]  edit_field,
  input  logic        alarm_view_req,
  input  logic        alarm_ringing,
  output logic [16:0] disp_time,
  output logic [5:0]  digit_blank,
  output logic        scan_tick,
  output logic [1:0]  view_state
);

  localparam int VW = $clog2(VIEW_TIMEOUT_S + 1);
  localparam logic [VW-1:0] VIEW_LAST = VW'(VIEW_TIMEOUT_S - 1);

  logic          blink_pulse_s;
  logic          sec_pulse_s;
  view_state_t   state_r;
  view_state_t   state_next_s;
  logic [VW-1:0] view_cnt_r;
  logic [VW-1:0] view_cnt_next_s;
  logic          blink_phase_r;
  logic          blink_next_s;
  logic [16:0]   disp_next_s;
  logic [5:0]    blank_base_s;
  logic [5:0]    blank_next_s;

  tick_gen #(.DIV(CLK_HZ / SCAN_HZ))        u_scan  (.clk(clk), .reset(reset), .tick(scan_tick));
  tick_gen #(.DIV(CLK_HZ / (2 * BLINK_HZ))) u_blink (.clk(clk), .reset(reset), .tick(blink_pulse_s));
  tick_gen #(.DIV(CLK_HZ))                  u_sec   (.clk(clk), .reset(reset), .tick(sec_pulse_s));

  assign view_state = state_r;

  // Next state, view timer and output selection; outputs follow the next state.
  always_comb begin
    state_next_s    = state_r;
    view_cnt_next_s = view_cnt_r;
    blink_next_s    = blink_pulse_s ? ~blink_phase_r : blink_phase_r;
    if (edit_active) begin
      state_next_s = EDIT;
    end else begin
      case (state_r)
        EDIT:       state_next_s = alarm_ringing ? RING : SHOW_CLOCK;
        RING:       state_next_s = alarm_ringing ? RING : SHOW_CLOCK;
        SHOW_CLOCK: begin
          if (alarm_ringing) begin
            state_next_s = RING;
          end else if (alarm_view_req) begin
            state_next_s    = SHOW_ALARM;
            view_cnt_next_s = '0;
          end else begin
            state_next_s = SHOW_CLOCK;
          end
        end
        SHOW_ALARM: begin
          if (alarm_ringing) begin
            state_next_s = RING;
          end else if (alarm_view_req) begin
            state_next_s = SHOW_CLOCK;
          end else if (sec_pulse_s) begin
            view_cnt_next_s = view_cnt_r + 1'b1;
            state_next_s    = (view_cnt_r == VIEW_LAST) ? SHOW_CLOCK : SHOW_ALARM;
          end else begin
            state_next_s = SHOW_ALARM;
          end
        end
        default:    state_next_s = SHOW_CLOCK;
      endcase
    end

    case (state_next_s)
      SHOW_CLOCK: begin disp_next_s = cur_time;   blank_base_s = MASK_NONE; end
      SHOW_ALARM: begin disp_next_s = alarm_time; blank_base_s = MASK_NONE; end
      EDIT:       begin
        disp_next_s  = edit_time;
        blank_base_s = blink_next_s ? field_mask(edit_field) : MASK_NONE;
      end
      RING:       begin
        disp_next_s  = cur_time;
        blank_base_s = blink_next_s ? MASK_ALL : MASK_NONE;
      end
      default:    begin disp_next_s = cur_time;   blank_base_s = MASK_NONE; end
    endcase
  end

`ifdef NIGHT_DIM_EN
  logic [1:0] dim_cnt_r;
  logic [1:0] dim_next_s;
  logic       dim_hit_s;

  // Display lit on only one scan period in four at night, in the plain views.
  always_comb begin
    dim_next_s   = scan_tick ? (dim_cnt_r + 2'd1) : dim_cnt_r;
    dim_hit_s    = ((state_next_s == SHOW_CLOCK) || (state_next_s == SHOW_ALARM)) &&
                   is_night(cur_time) && (dim_next_s != 2'd0);
    blank_next_s = dim_hit_s ? MASK_ALL : blank_base_s;
  end

  // Dim phase counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      dim_cnt_r <= 2'd0;
    end else begin
      dim_cnt_r <= dim_next_s;
    end
  end
`else
  assign blank_next_s = blank_base_s;
`endif

  // State, timers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= SHOW_CLOCK;
      view_cnt_r    <= '0;
      blink_phase_r <= 1'b0;
      disp_time     <= 17'd0;
      digit_blank   <= 6'b000000;
    end else begin
      state_r       <= state_next_s;
      view_cnt_r    <= view_cnt_next_s;
      blink_phase_r <= blink_next_s;
      disp_time     <= disp_next_s;
      digit_blank   <= blank_next_s;
    end
  end

endmodule

// File: tb/tb_display_sched.sv
// Directed bench for display_sched with shortened clock rates.
// Divider phases are modelled from the number of edges since reset release.
module tb_display_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] cur_time = 17'd0;
  logic [16:0] alarm_time = 17'd0;
  logic [16:0] edit_time = 17'd0;
  logic        edit_active = 1'b0;
  logic [1:0]  edit_field = 2'd3;
  logic        alarm_view_req = 1'b0;
  logic        alarm_ringing = 1'b0;
  logic [16:0] disp_time;
  logic [5:0]  digit_blank;
  logic        scan_tick;
  logic [1:0]  view_state;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  display_sched #(
    .CLK_HZ(100), .SCAN_HZ(10), .BLINK_HZ(5), .VIEW_TIMEOUT_S(3)
  ) dut (
    .clk(clk), .reset(reset), .cur_time(cur_time), .alarm_time(alarm_time),
    .edit_time(edit_time), .edit_active(edit_active), .edit_field(edit_field),
    .alarm_view_req(alarm_view_req), .alarm_ringing(alarm_ringing),
    .disp_time(disp_time), .digit_blank(digit_blank), .scan_tick(scan_tick),
    .view_state(view_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) edge_n <= 0;
    else       edge_n <= edge_n + 1;
  end

  // Number of pulses of a DIV divider that have taken effect after edge e.
  function automatic int toggles(input int e, input int div);
    if (e < 1) return 0;
    return (e - 1) / div;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int last_tick;
    int gap_bad;
    int pulses;
    reset = 1'b1;
    cur_time = 17'd45296;
    step(); step();
    vectors++;
    if (disp_time !== 17'd0 || digit_blank !== 6'b0 || view_state !== 2'd0 || scan_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: disp=%0d blank=%b view=%0d scan=%b, want 0/000000/0/0",
               disp_time, digit_blank, view_state, scan_tick);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (disp_time !== 17'd45296 || digit_blank !== 6'b0 || view_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_release: disp=%0d blank=%b view=%0d, want 45296/000000/0",
               disp_time, digit_blank, view_state);
    end
    last_tick = 0; gap_bad = 0; pulses = 0;
    for (int i = 0; i < 39; i++) begin
      step();
      if (scan_tick === 1'b1) begin
        pulses++;
        if (edge_n - last_tick != 10) gap_bad++;
        last_tick = edge_n;
      end
    end
    vectors++;
    if (pulses != 4 || gap_bad != 0) begin
      miscompares++;
      $display("FAIL scan_tick_period: pulses=%0d bad_gaps=%0d, want 4 pulses spaced 10", pulses, gap_bad);
    end
  endtask

  task automatic test_alarm_view();
    int e0;
    int exp_view;
    bit done;
    alarm_time = 17'd25200;
    alarm_view_req = 1'b1;
    step();
    alarm_view_req = 1'b0;
    e0 = edge_n;
    vectors++;
    if (view_state !== 2'd1 || disp_time !== 17'd25200) begin
      miscompares++;
      $display("FAIL alarm_view_enter: view=%0d disp=%0d, want 1/25200", view_state, disp_time);
    end
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      exp_view = (toggles(edge_n, 100) - toggles(e0, 100) >= 3) ? 0 : 1;
      vectors++;
      if (view_state !== 2'(exp_view)) begin
        miscompares++;
        $display("FAIL alarm_view_timeout: edge=%0d view=%0d, want %0d", edge_n, view_state, exp_view);
        done = 1'b1;
      end else if (exp_view == 0) begin
        done = 1'b1;
        vectors++;
        if (disp_time !== cur_time) begin
          miscompares++;
          $display("FAIL alarm_view_revert: disp=%0d, want %0d", disp_time, cur_time);
        end
      end
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL alarm_view_timeout_bound: view=%0d still not reverted", view_state);
    end
    alarm_view_req = 1'b1;
    step();
    alarm_view_req = 1'b0;
    step(); step(); step();
    vectors++;
    if (view_state !== 2'd1) begin
      miscompares++;
      $display("FAIL alarm_view_hold: view=%0d, want 1", view_state);
    end
    alarm_view_req = 1'b1;
    step();
    alarm_view_req = 1'b0;
    vectors++;
    if (view_state !== 2'd0 || disp_time !== 17'd45296) begin
      miscompares++;
      $display("FAIL alarm_view_toggle: view=%0d disp=%0d, want 0/45296", view_state, disp_time);
    end
  endtask

  task automatic test_edit_blink();
    logic [5:0] exp_blank;
    edit_time = 17'd3600;
    edit_field = 2'd1;
    edit_active = 1'b1;
    step();
    vectors++;
    if (view_state !== 2'd2 || disp_time !== 17'd3600) begin
      miscompares++;
      $display("FAIL edit_enter: view=%0d disp=%0d, want 2/3600", view_state, disp_time);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      exp_blank = (toggles(edge_n, 10) % 2 == 1) ? 6'b001100 : 6'b000000;
      vectors++;
      if (digit_blank !== exp_blank) begin
        miscompares++;
        $display("FAIL edit_blink_min: edge=%0d blank=%b, want %b", edge_n, digit_blank, exp_blank);
      end
    end
    edit_field = 2'd3;
    for (int i = 0; i < 25; i++) begin
      step();
      vectors++;
      if (digit_blank !== 6'b000000) begin
        miscompares++;
        $display("FAIL edit_field_none: edge=%0d blank=%b, want 000000", edge_n, digit_blank);
      end
    end
  endtask

  task automatic test_ring();
    logic [5:0] exp_blank;
    edit_active = 1'b0;
    step();
    alarm_view_req = 1'b1;
    step();
    alarm_view_req = 1'b0;
    vectors++;
    if (view_state !== 2'd1) begin
      miscompares++;
      $display("FAIL ring_setup_alarm_view: view=%0d, want 1", view_state);
    end
    alarm_ringing = 1'b1;
    step();
    vectors++;
    if (view_state !== 2'd3 || disp_time !== cur_time) begin
      miscompares++;
      $display("FAIL ring_enter: view=%0d disp=%0d, want 3/%0d", view_state, disp_time, cur_time);
    end
    alarm_view_req = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      alarm_view_req = 1'b0;
      exp_blank = (toggles(edge_n, 10) % 2 == 1) ? 6'b111111 : 6'b000000;
      vectors++;
      if (view_state !== 2'd3 || digit_blank !== exp_blank) begin
        miscompares++;
        $display("FAIL ring_flash: edge=%0d view=%0d blank=%b, want 3/%b", edge_n, view_state, digit_blank, exp_blank);
      end
    end
    edit_active = 1'b1;
    step();
    vectors++;
    if (view_state !== 2'd2 || disp_time !== 17'd3600) begin
      miscompares++;
      $display("FAIL ring_edit_override: view=%0d disp=%0d, want 2/3600", view_state, disp_time);
    end
    edit_active = 1'b0;
    step();
    vectors++;
    if (view_state !== 2'd3) begin
      miscompares++;
      $display("FAIL ring_after_edit: view=%0d, want 3", view_state);
    end
    alarm_ringing = 1'b0;
    step();
    vectors++;
    if (view_state !== 2'd0 || digit_blank !== 6'b0 || disp_time !== 17'd45296) begin
      miscompares++;
      $display("FAIL ring_exit: view=%0d blank=%b disp=%0d, want 0/000000/45296", view_state, digit_blank, disp_time);
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    edit_field = 2'd0;
    edit_active = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (toggles(edge_n, 10) % 2 == 1) found = 1'b1;
    end
    vectors++;
    if (!found || digit_blank !== 6'b000011 || view_state !== 2'd2) begin
      miscompares++;
      $display("FAIL reset_setup_edit: found=%0d blank=%b view=%0d, want 1/000011/2", found, digit_blank, view_state);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++;
    if (view_state !== 2'd0 || digit_blank !== 6'b0 || disp_time !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_mid_edit: view=%0d blank=%b disp=%0d, want 0/000000/0", view_state, digit_blank, disp_time);
    end
    edit_active = 1'b0;
    step();
    vectors++;
    if (view_state !== 2'd0 || disp_time !== 17'd45296) begin
      miscompares++;
      $display("FAIL reset_recover: view=%0d disp=%0d, want 0/45296", view_state, disp_time);
    end
  endtask

  task automatic test_night_dim();
    logic [5:0] exp_blank;
    logic [16:0] times [4];
    bit          night [4];
    times[0] = 17'd82800; night[0] = 1'b1;
    times[1] = 17'd43200; night[1] = 1'b0;
    times[2] = 17'd25199; night[2] = 1'b1;
    times[3] = 17'd25200; night[3] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      cur_time = times[t];
      for (int i = 0; i < 40; i++) begin
        step();
`ifdef NIGHT_DIM_EN
        exp_blank = (night[t] && (toggles(edge_n, 10) % 4 != 0)) ? 6'b111111 : 6'b000000;
`else
        exp_blank = 6'b000000;
`endif
        vectors++;
        if (digit_blank !== exp_blank || disp_time !== times[t]) begin
          miscompares++;
          $display("FAIL night_dim: time=%0d edge=%0d blank=%b disp=%0d, want %b/%0d",
                   times[t], edge_n, digit_blank, disp_time, exp_blank, times[t]);
        end
      end
    end
    cur_time = 17'd45296;
  endtask

  initial begin
    test_reset();
    test_alarm_view();
    test_edit_blink();
    test_ring();
    test_mid_reset();
    test_night_dim();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
